mem_rd_unit: RTL and testbench

Parametrised load unit between the CPU execute/memory stage and a synchronous data RAM port. It accepts one load request per handshake and issues a word-aligned read. It then waits a configurable read latency and extracts the addressed byte, half, word or double lane, with sign or zero extension. The result is returned over a valid/ready response channel tagged with the destination register. It replaces the single-cycle registered read path with latency-, width- and size-aware behaviour and back-pressure.

---
 rtl/mem_rd_pkg.sv | 36 +++
 rtl/mem_rd_align.sv | 61 ++++++
 rtl/mem_rd_unit.sv | 135 +++++++++++++
 tb/tb_mem_rd_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rd_pkg.sv
// Shared types and constants for the load path: access size, FSM state, and
// the alignment-fault helper used when MEM_RD_FAULT_EN is defined.
// No logic of its own; imported by mem_rd_align and mem_rd_unit.
package mem_rd_pkg;

    // Upper bound for the read-latency parameter; sizes the wait counter.
    localparam int RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_rd_state_t;

    // True when the low address bits are not naturally aligned for the size.
    // off is zero-extended to 3 bits on 32-bit builds, so a double access
    // there is flagged through the xlen64 term alone.
    function automatic logic mem_rd_misaligned(input logic [2:0] off,
                                               input mem_size_t size,
                                               input logic xlen64);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return off[0];
            SIZE_W:  return off[1:0] != 2'b00;
            default: return !xlen64 || (off != 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/mem_rd_align.sv
// Lane select plus sign/zero extension of one memory word.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: data_i raw RAM word, off_i low address bits, size_i access size,
//        sign_i extend with lane MSB when 1, data_o extended result.
module mem_rd_align
    import mem_rd_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]             data_i,
    input  logic [$clog2(XLEN/8)-1:0]   off_i,
    input  mem_size_t                   size_i,
    input  logic                        sign_i,
    output logic [XLEN-1:0]             data_o
);

    localparam int OFF_W = $clog2(XLEN/8);

    mem_size_t        eff_size;
    logic [OFF_W-1:0] byte_off;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  keep_mask;
    logic             lane_msb;

    always_comb begin
        eff_size = size_i;
        // A 32-bit datapath has no double lane; treat it as a full word.
        if ((XLEN == 32) && (size_i == SIZE_D)) begin
            eff_size = SIZE_W;
        end

        // Clear offset bits below the access size: aligned accesses keep
        // their lane index, misaligned ones are truncated to the lane below.
        byte_off = off_i & OFF_W'(~((4'd1 << eff_size) - 4'd1));
        shifted  = data_i >> {byte_off, 3'b000};

        keep_mask = '1;
        lane_msb  = shifted[XLEN-1];
        case (eff_size)
            SIZE_B: begin
                keep_mask = XLEN'(8'hFF);
                lane_msb  = shifted[7];
            end
            SIZE_H: begin
                keep_mask = XLEN'(16'hFFFF);
                lane_msb  = shifted[15];
            end
            SIZE_W: begin
                keep_mask = XLEN'(32'hFFFF_FFFF);
                lane_msb  = shifted[31];
            end
            default: begin
                keep_mask = '1;
                lane_msb  = shifted[XLEN-1];
            end
        endcase

        data_o = (shifted & keep_mask) | ((sign_i && lane_msb) ? ~keep_mask : '0);
    end

endmodule

// File: rtl/mem_rd_unit.sv
// Load unit: one request in flight, word-aligned RAM read, lane extract, tagged response.
// Latency: RD_LAT+1 cycles accept-to-response; 1 cycle for a faulted request.
// Backpressure: req_ready_o low from accept until the response handshake; response held while rsp_ready_i low.
// Ports: req_* load request (valid/ready), mem_rd_* synchronous RAM read port,
//        rsp_* response (valid/ready) with data, tag and error.
// Optional feature: define MEM_RD_FAULT_EN to trap misaligned / illegal-size loads
// (no RAM read, immediate error response); otherwise rsp_err_o is constant 0.
module mem_rd_unit
    import mem_rd_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RD_LAT = 1,
    parameter int TAG_W  = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [XLEN-1:0]  req_addr_i,
    input  logic [1:0]       req_size_i,
    input  logic             req_sign_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             mem_rd_en_o,
    output logic [XLEN-1:0]  mem_rd_addr_o,
    input  logic [XLEN-1:0]  mem_rd_data_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [XLEN-1:0]  rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_err_o
);

    localparam int OFF_W = $clog2(XLEN/8);
    localparam int CNT_W = $clog2(RD_LAT_MAX);

    mem_rd_state_t    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [OFF_W-1:0] off_q;
    mem_size_t        size_q;
    logic             sign_q;
    logic             rsp_valid_q;
    logic [XLEN-1:0]  rsp_data_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic [XLEN-1:0]  lane_data;
    logic             accept;
    logic             req_fault;

    // Reset gates the handshake combinationally so nothing is issued mid-reset.
    assign req_ready_o   = rst_n_i && (state_q == IDLE);
    assign accept        = req_valid_i && req_ready_o;
    assign mem_rd_en_o   = accept && !req_fault;
    assign mem_rd_addr_o = {req_addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};

`ifdef MEM_RD_FAULT_EN
    logic rsp_err_q;
    assign req_fault = mem_rd_misaligned(3'(req_addr_i[OFF_W-1:0]),
                                         mem_size_t'(req_size_i), XLEN == 64);
    assign rsp_err_o = rsp_err_q;
`else
    assign req_fault = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_tag_o   = rsp_tag_q;

    // Extraction works on the latched offset/size/sign against live RAM data;
    // its result is only captured in the final WAIT cycle.
    mem_rd_align #(
        .XLEN (XLEN)
    ) u_align (
        .data_i (mem_rd_data_i),
        .off_i  (off_q),
        .size_i (size_q),
        .sign_i (sign_q),
        .data_o (lane_data)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            off_q       <= '0;
            size_q      <= SIZE_B;
            sign_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
`ifdef MEM_RD_FAULT_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        off_q     <= req_addr_i[OFF_W-1:0];
                        size_q    <= mem_size_t'(req_size_i);
                        sign_q    <= req_sign_i;
                        rsp_tag_q <= req_tag_i;
`ifdef MEM_RD_FAULT_EN
                        rsp_err_q <= req_fault;
`endif
                        if (req_fault) begin
                            // No read was issued, so skip the wait entirely.
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_W'(RD_LAT - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_data_q  <= lane_data;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rd_unit.sv
`timescale 1ns/1ps
module tb_mem_rd_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared request/memory stimulus; per-instance valid and ready.
    logic        rst_n;
    logic [2:0]  req_vld;
    logic [2:0]  rsp_rdy;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        sign;
    logic [4:0]  tag;
    logic [63:0] mem_data;

    logic        rdy_a, en_a, vld_a, err_a;
    logic [31:0] maddr_a, rdata_a;
    logic [4:0]  tag_a;
    logic        rdy_b, en_b, vld_b, err_b;
    logic [31:0] maddr_b, rdata_b;
    logic [4:0]  tag_b;
    logic        rdy_c, en_c, vld_c, err_c;
    logic [63:0] maddr_c, rdata_c;
    logic [4:0]  tag_c;

    // a: XLEN=32 RD_LAT=1, b: XLEN=32 RD_LAT=3, c: XLEN=64 RD_LAT=2
    mem_rd_unit #(.XLEN(32), .RD_LAT(1), .TAG_W(5)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_vld[0]), .req_ready_o(rdy_a), .req_addr_i(addr[31:0]),
        .req_size_i(size), .req_sign_i(sign), .req_tag_i(tag),
        .mem_rd_en_o(en_a), .mem_rd_addr_o(maddr_a), .mem_rd_data_i(mem_data[31:0]),
        .rsp_valid_o(vld_a), .rsp_ready_i(rsp_rdy[0]), .rsp_data_o(rdata_a),
        .rsp_tag_o(tag_a), .rsp_err_o(err_a));

    mem_rd_unit #(.XLEN(32), .RD_LAT(3), .TAG_W(5)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_vld[1]), .req_ready_o(rdy_b), .req_addr_i(addr[31:0]),
        .req_size_i(size), .req_sign_i(sign), .req_tag_i(tag),
        .mem_rd_en_o(en_b), .mem_rd_addr_o(maddr_b), .mem_rd_data_i(mem_data[31:0]),
        .rsp_valid_o(vld_b), .rsp_ready_i(rsp_rdy[1]), .rsp_data_o(rdata_b),
        .rsp_tag_o(tag_b), .rsp_err_o(err_b));

    mem_rd_unit #(.XLEN(64), .RD_LAT(2), .TAG_W(5)) dut_c (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_vld[2]), .req_ready_o(rdy_c), .req_addr_i(addr),
        .req_size_i(size), .req_sign_i(sign), .req_tag_i(tag),
        .mem_rd_en_o(en_c), .mem_rd_addr_o(maddr_c), .mem_rd_data_i(mem_data),
        .rsp_valid_o(vld_c), .rsp_ready_i(rsp_rdy[2]), .rsp_data_o(rdata_c),
        .rsp_tag_o(tag_c), .rsp_err_o(err_c));

    logic [2:0]  o_rdy, o_en, o_vld, o_err;
    logic [63:0] o_addr [3];
    logic [63:0] o_data [3];
    logic [4:0]  o_tag  [3];

    assign o_rdy = {rdy_c, rdy_b, rdy_a};
    assign o_en  = {en_c, en_b, en_a};
    assign o_vld = {vld_c, vld_b, vld_a};
    assign o_err = {err_c, err_b, err_a};
    assign o_addr[0] = {32'b0, maddr_a};
    assign o_addr[1] = {32'b0, maddr_b};
    assign o_addr[2] = maddr_c;
    assign o_data[0] = {32'b0, rdata_a};
    assign o_data[1] = {32'b0, rdata_b};
    assign o_data[2] = rdata_c;
    assign o_tag[0]  = tag_a;
    assign o_tag[1]  = tag_b;
    assign o_tag[2]  = tag_c;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    // Called at a negedge with the instance idle; returns at the negedge
    // after the response handshake, so consecutive calls are back-to-back.
    task automatic do_load(input string nm, input int d, input logic [63:0] a,
                           input logic [1:0] sz, input logic sg, input logic [4:0] tg,
                           input logic [63:0] md, input int lat, input int stall,
                           input logic [63:0] exp_addr, input logic [63:0] exp_data);
        addr = a; size = sz; sign = sg; tag = tg;
        mem_data = 64'hDEAD_BEEF_DEAD_BEEF;
        req_vld[d] = 1'b1;
        #1;
        chk({nm, ".rdy"},   64'(o_rdy[d]), 64'd1);
        chk({nm, ".en"},    64'(o_en[d]),  64'd1);
        chk({nm, ".maddr"}, o_addr[d],     exp_addr);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            req_vld[d] = 1'b0;
            addr = '1; tag = ~tg; sign = ~sg;
            if (i == lat) mem_data = md;
            #1;
            chk({nm, ".wait_vld"}, 64'(o_vld[d]), 64'd0);
            chk({nm, ".wait_rdy"}, 64'(o_rdy[d]), 64'd0);
            chk({nm, ".wait_en"},  64'(o_en[d]),  64'd0);
        end
        @(negedge clk);
        mem_data = 64'h0F0F_0F0F_0F0F_0F0F;
        #1;
        chk({nm, ".vld"},  64'(o_vld[d]), 64'd1);
        chk({nm, ".data"}, o_data[d],     exp_data);
        chk({nm, ".tag"},  64'(o_tag[d]), 64'(tg));
        chk({nm, ".err"},  64'(o_err[d]), 64'd0);
        chk({nm, ".rdy"},  64'(o_rdy[d]), 64'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            #1;
            chk({nm, ".stall_vld"},  64'(o_vld[d]), 64'd1);
            chk({nm, ".stall_data"}, o_data[d],     exp_data);
            chk({nm, ".stall_tag"},  64'(o_tag[d]), 64'(tg));
            chk({nm, ".stall_rdy"},  64'(o_rdy[d]), 64'd0);
        end
        rsp_rdy[d] = 1'b1;
        @(negedge clk);
        rsp_rdy[d] = 1'b0;
        #1;
        chk({nm, ".done_vld"}, 64'(o_vld[d]), 64'd0);
        chk({nm, ".done_rdy"}, 64'(o_rdy[d]), 64'd1);
    endtask

`ifdef MEM_RD_FAULT_EN
    task automatic fault_case(input string nm, input int d, input logic [63:0] a,
                              input logic [1:0] sz, input logic [4:0] tg);
        addr = a; size = sz; sign = 1'b1; tag = tg;
        mem_data = '1;
        req_vld[d] = 1'b1;
        #1;
        chk({nm, ".en"},  64'(o_en[d]),  64'd0);
        chk({nm, ".rdy"}, 64'(o_rdy[d]), 64'd1);
        @(negedge clk);
        req_vld[d] = 1'b0;
        #1;
        chk({nm, ".vld"},  64'(o_vld[d]), 64'd1);
        chk({nm, ".err"},  64'(o_err[d]), 64'd1);
        chk({nm, ".data"}, o_data[d],     64'd0);
        chk({nm, ".tag"},  64'(o_tag[d]), 64'(tg));
        chk({nm, ".en1"},  64'(o_en[d]),  64'd0);
        rsp_rdy[d] = 1'b1;
        @(negedge clk);
        rsp_rdy[d] = 1'b0;
        #1;
        chk({nm, ".done_vld"}, 64'(o_vld[d]), 64'd0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with requests asserted: nothing may be issued or accepted.
        rst_n = 1'b0; req_vld = 3'b111; rsp_rdy = 3'b000;
        addr = 64'h100; size = 2'd2; sign = 1'b0; tag = 5'h1F; mem_data = '1;
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst.rdy",  64'(o_rdy[d]), 64'd0);
            chk("rst.en",   64'(o_en[d]),  64'd0);
            chk("rst.vld",  64'(o_vld[d]), 64'd0);
            chk("rst.data", o_data[d],     64'd0);
            chk("rst.tag",  64'(o_tag[d]), 64'd0);
            chk("rst.err",  64'(o_err[d]), 64'd0);
        end
        req_vld = 3'b000;
        rst_n = 1'b1;
        #1;
        chk("rel.rdy", 64'(o_rdy), 64'h7);
        @(negedge clk);

        // XLEN=32, RD_LAT=1
        do_load("a_b103s", 0, 64'h103, 2'd0, 1'b1, 5'h05, 64'h8011_2233, 1, 0, 64'h100, 64'hFFFF_FF80);
        do_load("a_h102u", 0, 64'h102, 2'd1, 1'b0, 5'h1A, 64'h8011_2233, 1, 0, 64'h100, 64'h0000_8011);
        do_load("a_h102s", 0, 64'h102, 2'd1, 1'b1, 5'h11, 64'h8011_2233, 1, 0, 64'h100, 64'hFFFF_8011);
        do_load("a_b101s", 0, 64'h101, 2'd0, 1'b1, 5'h02, 64'h8011_2233, 1, 0, 64'h100, 64'h0000_0022);
        do_load("a_h100s", 0, 64'h100, 2'd1, 1'b1, 5'h13, 64'h8011_2233, 1, 0, 64'h100, 64'h0000_2233);
        do_load("a_w104s", 0, 64'h104, 2'd2, 1'b1, 5'h14, 64'hF00D_0001, 1, 0, 64'h104, 64'hF00D_0001);

`ifdef MEM_RD_FAULT_EN
        fault_case("f_w102", 0, 64'h102, 2'd2, 5'h03);
        fault_case("f_d32",  0, 64'h104, 2'd3, 5'h04);
        fault_case("f_d64",  2, 64'h00C, 2'd3, 5'h05);
        fault_case("f_h64",  2, 64'h009, 2'd1, 5'h06);
`else
        do_load("n_w102", 0, 64'h102, 2'd2, 1'b0, 5'h03, 64'h8011_2233, 1, 0, 64'h100, 64'h8011_2233);
        do_load("n_d32",  0, 64'h104, 2'd3, 1'b1, 5'h04, 64'h8011_2233, 1, 0, 64'h104, 64'h8011_2233);
        do_load("n_h64",  2, 64'h009, 2'd1, 1'b1, 5'h06, 64'h1122_3344_5566_8877, 2, 0,
                64'h8, 64'hFFFF_FFFF_FFFF_8877);
`endif

        // XLEN=32, RD_LAT=3: stalled response, then back-to-back accept
        do_load("b_w40",  1, 64'h40, 2'd2, 1'b1, 5'h0F, 64'h1234_5678, 3, 4, 64'h40, 64'h1234_5678);
        do_load("b_b42",  1, 64'h42, 2'd0, 1'b1, 5'h10, 64'h1234_5678, 3, 0, 64'h40, 64'h0000_0034);
        do_load("b_h42s", 1, 64'h42, 2'd1, 1'b1, 5'h12, 64'h9ABC_0000, 3, 1, 64'h40, 64'hFFFF_9ABC);

        // XLEN=64, RD_LAT=2
        do_load("c_d08",  2, 64'h08, 2'd3, 1'b1, 5'h08, 64'h8000_0000_0000_0001, 2, 0,
                64'h08, 64'h8000_0000_0000_0001);
        do_load("c_w0Cs", 2, 64'h0C, 2'd2, 1'b1, 5'h09, 64'h8000_0000_1234_5678, 2, 0,
                64'h08, 64'hFFFF_FFFF_8000_0000);
        do_load("c_w08u", 2, 64'h08, 2'd2, 1'b0, 5'h0A, 64'hAB11_2233_4455_6677, 2, 0,
                64'h08, 64'h0000_0000_4455_6677);
        do_load("c_b0Fu", 2, 64'h0F, 2'd0, 1'b0, 5'h0B, 64'hAB11_2233_4455_6677, 2, 2,
                64'h08, 64'h0000_0000_0000_00AB);
        do_load("c_h0Es", 2, 64'h0E, 2'd1, 1'b1, 5'h0C, 64'hAB11_2233_4455_6677, 2, 0,
                64'h08, 64'hFFFF_FFFF_FFFF_AB11);

        // Reset during WAIT of an RD_LAT=2 load discards it.
        addr = 64'h10; size = 2'd3; sign = 1'b0; tag = 5'h07;
        mem_data = 64'h5555_5555_5555_5555;
        req_vld[2] = 1'b1;
        #1;
        chk("r.en0", 64'(o_en[2]), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("r.rdy_in_rst", 64'(o_rdy[2]), 64'd0);
        chk("r.en_in_rst",  64'(o_en[2]),  64'd0);
        @(negedge clk);
        #1;
        chk("r.vld",  64'(o_vld[2]), 64'd0);
        chk("r.data", o_data[2],     64'd0);
        chk("r.tag",  64'(o_tag[2]), 64'd0);
        chk("r.rdy",  64'(o_rdy[2]), 64'd0);
        req_vld[2] = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("r.rdy_rel", 64'(o_rdy[2]), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("r.vld_after", 64'(o_vld[2]), 64'd0);
        end
        do_load("c_post", 2, 64'h10, 2'd3, 1'b0, 5'h07, 64'h0123_4567_89AB_CDEF, 2, 0,
                64'h10, 64'h0123_4567_89AB_CDEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
